// File: rtl/pico_pkg.sv
// Shared types for the pico-MIPS control path: opcode classes and PC-control FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package pico_pkg;

  // Decoded opcode class presented by instruction decode; 7 is reserved and treated as NOP.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BRA  = 3'd4,
    OP_WAIT = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  // PC-control sequencing states.
  typedef enum logic [1:0] {
    RUN          = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    STOPPED      = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pc_ctrl_btn_cond.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce (PICO_BTN_DEBOUNCE_EN), rise detect.
// Latency: level 2 cycles after btn changes (plus DebounceCycles when debounced); rise is a 1-cycle pulse.
// Backpressure: none; free-running sampler.
module btn_cond #(
  parameter int DebounceCycles = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn,
  output logic btn_level,
  output logic btn_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Synchroniser chain and edge-detect history follow the conditioned level.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = btn_level;
  end

  // Synchroniser and previous-level registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef PICO_BTN_DEBOUNCE_EN
  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Count consecutive samples disagreeing with the accepted level; flip once the run is long enough.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign btn_level = level_q;
`else
  // Without debounce the synchronised level is used directly and the debounce depth has no effect.
  localparam int unused_debounce_cycles = DebounceCycles;

  assign btn_level = sync2_q;
`endif

  assign btn_rise = btn_level & ~prev_q;

endmodule

// File: rtl/pc_ctrl.sv
// PC control: drives rel_branch/offset/halt from opcode class, WAIT push-button handshake, permanent HALT.
// Latency: Mealy outputs in the same cycle as opcode; btn seen 2 cycles late (+DebounceCycles with PICO_BTN_DEBOUNCE_EN).
// Backpressure: halt holds the PC while waiting for the button or once stopped.
module pc_ctrl
  import pico_pkg::*;
#(
  parameter int AddrSz         = 6,
  parameter int DebounceCycles = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        opcode,
  input  logic [AddrSz-1:0] imm,
  input  logic              zero,
  input  logic              btn,
  output logic              rel_branch,
  output logic [AddrSz-1:0] offset,
  output logic              halt,
  output logic              in_latch,
  output logic              stopped
);

  ctrl_state_t state_q, state_d;
  op_t         op;
  logic        btn_level;
  logic        btn_rise;
  logic        rb_raw, halt_raw, latch_raw, stop_raw;

  btn_cond #(
    .DebounceCycles(DebounceCycles)
  ) u_btn_cond (
    .clk      (clk),
    .n_reset  (n_reset),
    .btn      (btn),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
  );

  assign op = op_t'(opcode);

  // Next-state and raw output decode; branches only resolve in RUN.
  always_comb begin
    state_d   = state_q;
    rb_raw    = 1'b0;
    halt_raw  = 1'b0;
    latch_raw = 1'b0;
    stop_raw  = 1'b0;
    case (state_q)
      RUN: begin
        case (op)
          OP_BEQ:  rb_raw = zero;
          OP_BNE:  rb_raw = ~zero;
          OP_BRA:  rb_raw = 1'b1;
          OP_WAIT: begin
            halt_raw = 1'b1;
            state_d  = WAIT_PRESS;
          end
          OP_HALT: begin
            halt_raw = 1'b1;
            state_d  = STOPPED;
          end
          default: ;
        endcase
      end
      WAIT_PRESS: begin
        halt_raw = 1'b1;
        if (btn_rise) begin
          latch_raw = 1'b1;
          state_d   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_level) begin
          halt_raw = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      STOPPED: begin
        halt_raw = 1'b1;
        stop_raw = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held so the PC sees a quiet interface asynchronously.
  always_comb begin
    rel_branch = n_reset & rb_raw;
    halt       = n_reset & halt_raw;
    in_latch   = n_reset & latch_raw;
    stopped    = n_reset & stop_raw;
    offset     = rel_branch ? imm : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed literal checks plus randomized traffic against a cycle-level behavioural model.
// Latency: model predicts outputs every cycle, sampled on the falling edge.
// Backpressure: n/a.
module tb_pc_ctrl;
  import pico_pkg::*;

  localparam int AW  = 6;
  localparam int DBC = 4;
`ifdef PICO_BTN_DEBOUNCE_EN
  localparam int LAT = 2 + DBC;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [2:0]    opcode = 3'd0;
  logic [AW-1:0] imm = '0;
  logic          zero = 1'b0;
  logic          btn = 1'b0;
  logic          rel_branch;
  logic [AW-1:0] offset;
  logic          halt;
  logic          in_latch;
  logic          stopped;

  int total = 0;
  int bad   = 0;

  pc_ctrl #(
    .AddrSz(AW),
    .DebounceCycles(DBC)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .opcode    (opcode),
    .imm       (imm),
    .zero      (zero),
    .btn       (btn),
    .rel_branch(rel_branch),
    .offset    (offset),
    .halt      (halt),
    .in_latch  (in_latch),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 executing, 1 waiting for a press, 2 waiting for release, 3 stopped.
  int   mode;
  // Raw btn of the previous three cycles: h1 = last cycle, h2 = two back, h3 = three back.
  logic h1, h2, h3;
  logic dl;      // debounced level (debounce build)
  int   dcnt;
  logic sprev;   // synchronised level of previous cycle

  always @(negedge clk) begin
    logic          e_rb, e_halt, e_lat, e_stop, lvl, lvl_old;
    logic [AW-1:0] e_off;
    e_rb = 1'b0; e_halt = 1'b0; e_lat = 1'b0; e_stop = 1'b0;
    lvl = 1'b0; lvl_old = 1'b0;
    if (!n_reset) begin
      mode = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      dl = 1'b0; dcnt = 0; sprev = 1'b0;
    end else begin
`ifdef PICO_BTN_DEBOUNCE_EN
      lvl_old = dl;
      if (sprev != dl) begin
        dcnt++;
        if (dcnt == DBC) begin
          dl = ~dl;
          dcnt = 0;
        end
      end else begin
        dcnt = 0;
      end
      lvl = dl;
      sprev = h2;
`else
      lvl = h2;
      lvl_old = h3;
`endif
      case (mode)
        0: begin
          if (opcode == OP_BEQ) e_rb = zero;
          else if (opcode == OP_BNE) e_rb = ~zero;
          else if (opcode == OP_BRA) e_rb = 1'b1;
          else if (opcode == OP_WAIT) begin e_halt = 1'b1; mode = 1; end
          else if (opcode == OP_HALT) begin e_halt = 1'b1; mode = 3; end
        end
        1: begin
          e_halt = 1'b1;
          if (lvl && !lvl_old) begin e_lat = 1'b1; mode = 2; end
        end
        2: begin
          e_halt = lvl;
          if (!lvl) mode = 0;
        end
        default: begin e_halt = 1'b1; e_stop = 1'b1; end
      endcase
      h3 = h2; h2 = h1; h1 = btn;
    end
    e_off = e_rb ? imm : '0;
    chk("m_rel_branch", 32'(rel_branch), 32'(e_rb));
    chk("m_offset",     32'(offset),     32'(e_off));
    chk("m_halt",       32'(halt),       32'(e_halt));
    chk("m_in_latch",   32'(in_latch),   32'(e_lat));
    chk("m_stopped",    32'(stopped),    32'(e_stop));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [2:0] op, input logic [AW-1:0] im, input logic z, input logic b);
    @(posedge clk);
    #1;
    opcode = op; imm = im; zero = z; btn = b;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset: outputs quiet even with a branch presented.
    opcode = OP_BRA; imm = 6'd5;
    #2;
    chk("rst_rel_branch", 32'(rel_branch), 32'd0);
    chk("rst_offset",     32'(offset),     32'd0);
    chk("rst_halt",       32'(halt),       32'd0);
    chk("rst_stopped",    32'(stopped),    32'd0);
    opcode = OP_ALU; imm = '0;
    @(negedge clk);
    @(posedge clk);
    #1 n_reset = 1'b1;

    repeat (5) begin
      step(OP_ALU, AW'($urandom), 1'($urandom), 1'b0);
      settle();
      chk("alu_rel_branch", 32'(rel_branch), 32'd0);
      chk("alu_halt",       32'(halt),       32'd0);
    end
    chk("stopped_after_rst", 32'(stopped), 32'd0);

    step(OP_BEQ, 6'd10, 1'b1, 1'b0); settle();
    chk("beq_taken_rb",  32'(rel_branch), 32'd1);
    chk("beq_taken_off", 32'(offset),     32'd10);
    step(OP_BEQ, 6'd10, 1'b0, 1'b0); settle();
    chk("beq_nt_rb",  32'(rel_branch), 32'd0);
    chk("beq_nt_off", 32'(offset),     32'd0);
    step(OP_BNE, 6'd10, 1'b0, 1'b0); settle();
    chk("bne_taken_off", 32'(offset), 32'd10);
    step(OP_BNE, 6'd10, 1'b1, 1'b0); settle();
    chk("bne_nt_rb", 32'(rel_branch), 32'd0);
    step(OP_BRA, 6'h3E, 1'b0, 1'b0); settle();
    chk("bra_rb",  32'(rel_branch), 32'd1);
    chk("bra_off", 32'(offset),     32'h3E);
    step(OP_BRA, 6'd0, 1'b0, 1'b0); settle();
    chk("bra_self_loop_rb", 32'(rel_branch), 32'd1);

    // WAIT with button idle, then press and release.
    repeat (8) begin
      step(OP_WAIT, 6'd3, 1'b1, 1'b0); settle();
      chk("wait_idle_halt",  32'(halt),       32'd1);
      chk("wait_idle_latch", 32'(in_latch),   32'd0);
      chk("wait_idle_rb",    32'(rel_branch), 32'd0);
    end
    for (int i = 0; i <= LAT + 3; i++) begin
      step(OP_WAIT, 6'd3, 1'b1, 1'b1); settle();
      chk("press_latch", 32'(in_latch), 32'(i == LAT));
      chk("press_halt",  32'(halt),     32'd1);
    end
    for (int i = 0; i <= LAT; i++) begin
      step(OP_WAIT, 6'd3, 1'b1, 1'b0); settle();
      chk("release_halt", 32'(halt), 32'(i < LAT));
    end
    step(OP_ALU, 6'd0, 1'b0, 1'b0); settle();
    chk("after_wait_halt", 32'(halt), 32'd0);

    // Button already held when WAIT arrives: needs release then a fresh press.
    repeat (LAT + 3) step(OP_ALU, 6'd0, 1'b0, 1'b1);
    repeat (6) begin
      step(OP_WAIT, 6'd0, 1'b0, 1'b1); settle();
      chk("held_no_latch", 32'(in_latch), 32'd0);
      chk("held_halt",     32'(halt),     32'd1);
    end
    repeat (LAT + 2) begin
      step(OP_WAIT, 6'd0, 1'b0, 1'b0); settle();
      chk("held_gap_latch", 32'(in_latch), 32'd0);
    end
    for (int i = 0; i <= LAT + 1; i++) begin
      step(OP_WAIT, 6'd0, 1'b0, 1'b1); settle();
      chk("repress_latch", 32'(in_latch), 32'(i == LAT));
    end
    for (int i = 0; i <= LAT; i++) begin
      step(OP_WAIT, 6'd0, 1'b0, 1'b0); settle();
      chk("repress_release_halt", 32'(halt), 32'(i < LAT));
    end

    // HALT: permanent stop, immune to branches and button.
    step(OP_HALT, 6'd0, 1'b0, 1'b0); settle();
    chk("halt_exec_halt", 32'(halt), 32'd1);
    repeat (10) begin
      step(OP_BRA, AW'($urandom), 1'($urandom), 1'($urandom));
      settle();
      chk("stop_halt",    32'(halt),       32'd1);
      chk("stop_stopped", 32'(stopped),    32'd1);
      chk("stop_rb",      32'(rel_branch), 32'd0);
    end
    @(posedge clk);
    #1;
    opcode = OP_BRA; imm = 6'd7; n_reset = 1'b0;
    #1;
    chk("midstop_rst_halt",    32'(halt),       32'd0);
    chk("midstop_rst_stopped", 32'(stopped),    32'd0);
    chk("midstop_rst_rb",      32'(rel_branch), 32'd0);
    chk("midstop_rst_off",     32'(offset),     32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 n_reset = 1'b1;
    settle();
    chk("post_rst_run_rb",  32'(rel_branch), 32'd1);
    chk("post_rst_run_off", 32'(offset),     32'd7);

    // Randomized traffic with occasional resets.
    for (int c = 1; c <= 3000; c++) begin
      int       r;
      logic [2:0] op;
      logic     b;
      r = int'($urandom_range(0, 99));
      if (r < 20)      op = OP_ALU;
      else if (r < 30) op = OP_NOP;
      else if (r < 45) op = OP_BEQ;
      else if (r < 60) op = OP_BNE;
      else if (r < 72) op = OP_BRA;
      else if (r < 90) op = OP_WAIT;
      else if (r < 92) op = OP_HALT;
      else             op = OP_RSVD;
      b = ($urandom_range(0, 5) == 0) ? ~btn : btn;
      step(op, AW'($urandom), 1'($urandom), b);
      if (c % 300 == 0) n_reset = 1'b0;
      else n_reset = 1'b1;
    end

    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Control-side driver of the program counter.
- Takes the decoded opcode class, branch immediate and ALU zero flag of the instruction at the current PC address.
- Drives the PC's rel_branch, offset and halt inputs.
- Implements the wait-for-input handshake against an external push-button, plus permanent stop.
- Sits between instruction decode and the PC register in the pico-MIPS core.

Parameters:
AddrSz, 6, width of PC address and branch offset (two's complement, wraps modulo 2^AddrSz)
DebounceCycles, 4, consecutive stable samples required before a button change is accepted (used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock, all state on rising edge
n_reset  input  1  asynchronous active-low reset
opcode  input  3  decoded opcode class (pico_pkg::op_t) of the instruction at the current PC
imm  input  AddrSz  signed relative branch offset from the instruction
zero  input  1  registered ALU zero flag
btn  input  1  asynchronous push-button, active high
rel_branch  output  1  to PC: add offset instead of +1
offset  output  AddrSz  to PC: branch offset
halt  output  1  to PC: hold address
in_latch  output  1  one-cycle pulse: register file captures switch input
stopped  output  1  high once HALT has executed

Behaviour:
- Reset (async, n_reset=0): state=RUN, synchroniser flops and btn_prev=0, debounce counter=0. Outputs: rel_branch=0, offset=0, halt=0, in_latch=0, stopped=0. Reset mid-wait or mid-stop returns to RUN immediately.
- btn passes through a 2-flop synchroniser giving btn_s (2-cycle latency). btn_rise = btn_s & ~btn_prev; btn_prev is registered each cycle.
- Outputs are Mealy combinational from state and inputs; the PC acts on them at the next rising edge (zero added latency).
- State RUN:
  - OP_ALU/OP_NOP: all outputs 0; PC increments.
  - OP_BEQ: rel_branch=zero.
  - OP_BNE: rel_branch=~zero.
  - OP_BRA: rel_branch=1.
  - offset=imm when rel_branch=1, else 0.
  - OP_WAIT: halt=1; next state WAIT_PRESS.
  - OP_HALT: halt=1; next state STOPPED.
  - Reserved opcodes: behave as NOP.
- State WAIT_PRESS: halt=1. On btn_rise: in_latch=1 for that cycle; next state WAIT_RELEASE.
  - A button already held on entry is ignored until released and pressed again (rising edge required).
- State WAIT_RELEASE: halt=1 while btn_s=1. When btn_s=0: halt=0 (PC steps past WAIT); next state RUN.
- State STOPPED: halt=1, stopped=1 permanently; only reset exits. Branches and btn are ignored.
- rel_branch and halt are never asserted together. Outside RUN, rel_branch=0 and offset=0.
- Branch target wraps modulo 2^AddrSz. imm=0 on a taken branch gives a self-loop; legal, no special handling.

Optional Feature:
PICO_BTN_DEBOUNCE_EN
- Defined: btn_s feeds a counter; the debounced level changes only after DebounceCycles consecutive samples differing from the current debounced level. btn_rise and the release test use the debounced level. Counter clears on any agreeing sample and on reset.
- Undefined: no counter; the synchroniser output is used directly; DebounceCycles is unused.

Decomposition:
- pico_pkg holds:
  - op_t enum: OP_NOP=0, OP_ALU=1, OP_BEQ=2, OP_BNE=3, OP_BRA=4, OP_WAIT=5, OP_HALT=6, 7 reserved.
  - ctrl_state_t enum: RUN, WAIT_PRESS, WAIT_RELEASE, STOPPED.
- Sub-module btn_cond: synchroniser, optional debounce and edge detect. Outputs btn_level and btn_rise. pc_ctrl contains the FSM and output decode only.

Test Plan:
- Reset then opcode=OP_ALU for 5 cycles -> rel_branch=0, halt=0 throughout; stopped=0 after reset.
- opcode=OP_BEQ, imm=6'd10, zero=1 -> rel_branch=1, offset=10 same cycle. zero=0 -> rel_branch=0, offset=0. OP_BNE gives the inverse. OP_BRA imm=6'h3E -> rel_branch=1, offset=0x3E (-2).
- OP_WAIT with btn=0 for 8 cycles -> halt=1, in_latch=0. Raise btn -> exactly one in_latch pulse 2 cycles later (no debounce). Halt stays 1 while held. Drop btn -> halt=0 two cycles after drop, state RUN.
- btn already high when OP_WAIT arrives -> no in_latch until btn goes low then high again.
- OP_HALT -> halt=1, stopped=1 indefinitely despite OP_BRA inputs and btn toggles. Assert n_reset=0 mid-stop -> all outputs 0 asynchronously.
- With PICO_BTN_DEBOUNCE_EN, DebounceCycles=4: 2-cycle btn glitch in WAIT_PRESS -> no in_latch. Stable press -> in_latch 2+4 cycles after the edge.
